// File: rtl/reg_arbiter_pkg.sv
// Shared types and defaults for the two-requester register-file arbiter.
// Holds the FSM state encoding and the default data/address widths.
package reg_arbiter_pkg;

  localparam int unsigned DefaultDataW = 8;
  localparam int unsigned DefaultAddrW = 2;
  localparam int unsigned NumReq       = 2;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StIssue  = 2'd1,
    StWaitRd = 2'd2,
    StDone   = 2'd3
  } state_e;

  function automatic logic [NumReq-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/registers.sv
// Small register file used behind the arbiter: writes on enable with read_write=0,
// registers the selected word onto data_bus_out on enable with read_write=1.
module registers
  import reg_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] register_select,
  input  logic              mem_enable,
  input  logic              read_write,
  input  logic [DATA_W-1:0] data_bus_in,
  output logic [DATA_W-1:0] data_bus_out
);

  localparam int unsigned NumRegs = 1 << ADDR_W;

  logic [DATA_W-1:0] mem_q [NumRegs];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        mem_q[i] <= '0;
      end
      data_bus_out <= '0;
    end else if (mem_enable) begin
      if (read_write) begin
        data_bus_out <= mem_q[register_select];
      end else begin
        mem_q[register_select] <= data_bus_in;
      end
    end
  end

endmodule

// File: rtl/rr_arbiter_2.sv
// Two-way round-robin arbiter; the pointer names the requester that wins a tie
// and moves to the loser whenever a grant is taken.
module rr_arbiter_2 (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  output logic       valid,
  output logic       grant_idx
);

  logic prio_q;

  always_comb begin
    valid     = |req;
    grant_idx = 1'b0;
    case (req)
      2'b01:   grant_idx = 1'b0;
      2'b10:   grant_idx = 1'b1;
      2'b11:   grant_idx = prio_q;
      default: grant_idx = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      prio_q <= 1'b0;
    end else if (advance && valid) begin
      prio_q <= ~grant_idx;
    end
  end

endmodule

// File: rtl/reg_arbiter.sv
// Arbitrates two requesters onto a single register-file port, one op at a time.
// All outputs except busy are registered and follow the IDLE/ISSUE/WAIT_RD/DONE FSM.
module reg_arbiter
  import reg_arbiter_pkg::*;
#(
  parameter int unsigned DATA_W = DefaultDataW,
  parameter int unsigned ADDR_W = DefaultAddrW
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          req,
  input  logic [1:0]          we,
  input  logic [2*ADDR_W-1:0] addr,
  input  logic [2*DATA_W-1:0] wdata,
  output logic [1:0]          gnt,
  output logic [1:0]          done,
  output logic [DATA_W-1:0]   rdata,
  output logic                busy,
  output logic [ADDR_W-1:0]   rf_select,
  output logic                rf_enable,
  output logic                rf_read_write,
  output logic [DATA_W-1:0]   rf_wdata,
  input  logic [DATA_W-1:0]   rf_rdata
);

  state_e            state_q;
  logic              win_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic [1:0]        gnt_q;
  logic [1:0]        done_q;
  logic [DATA_W-1:0] rdata_q;
  logic              rf_enable_q;
  logic              rf_rw_q;
  logic [ADDR_W-1:0] rf_select_q;
  logic [DATA_W-1:0] rf_wdata_q;

  logic              arb_valid;
  logic              arb_idx;
  logic              arb_advance;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  // The pointer only moves when IDLE actually accepts a request.
  assign arb_advance = (state_q == StIdle) && arb_valid;

  rr_arbiter_2 u_arb (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .advance   (arb_advance),
    .valid     (arb_valid),
    .grant_idx (arb_idx)
  );

  always_comb begin
    sel_we    = arb_idx ? we[1] : we[0];
    sel_addr  = arb_idx ? addr[2*ADDR_W-1:ADDR_W] : addr[ADDR_W-1:0];
    sel_wdata = arb_idx ? wdata[2*DATA_W-1:DATA_W] : wdata[DATA_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      win_q       <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      gnt_q       <= '0;
      done_q      <= '0;
      rdata_q     <= '0;
      rf_enable_q <= 1'b0;
      rf_rw_q     <= 1'b0;
      rf_select_q <= '0;
      rf_wdata_q  <= '0;
    end else begin
      // Pulses and port drives default to idle values; each state re-asserts its own.
      gnt_q       <= '0;
      done_q      <= '0;
      rf_enable_q <= 1'b0;
      rf_rw_q     <= 1'b0;
      rf_select_q <= '0;
      rf_wdata_q  <= '0;
      case (state_q)
        StIdle: begin
          if (arb_valid) begin
            state_q     <= StIssue;
            win_q       <= arb_idx;
            we_q        <= sel_we;
            addr_q      <= sel_addr;
            wdata_q     <= sel_wdata;
            gnt_q       <= idx_to_onehot(arb_idx);
            rf_enable_q <= 1'b1;
            rf_rw_q     <= ~sel_we;
            rf_select_q <= sel_addr;
            rf_wdata_q  <= sel_wdata;
          end
        end
        StIssue: begin
          if (we_q) begin
            state_q <= StDone;
            done_q  <= idx_to_onehot(win_q);
          end else begin
            state_q     <= StWaitRd;
            rf_rw_q     <= 1'b1;
            rf_select_q <= addr_q;
          end
        end
        StWaitRd: begin
          rdata_q <= rf_rdata;
          state_q <= StDone;
          done_q  <= idx_to_onehot(win_q);
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign gnt           = gnt_q;
  assign done          = done_q;
  assign rdata         = rdata_q;
  assign busy          = (state_q != StIdle);
  assign rf_select     = rf_select_q;
  assign rf_enable     = rf_enable_q;
  assign rf_read_write = rf_rw_q;
  assign rf_wdata      = rf_wdata_q;

endmodule
